// File: rtl/nmi_arbiter.sv
// Round-robin arbiter sharing the Z80 NMI line between magic, pause, fast-forward and external requesters.
// Optional post-service frame holdoff is compiled in with `define NMI_HOLDOFF_EN.
module nmi_arbiter #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT_W = 16
`ifdef NMI_HOLDOFF_EN
  ,parameter int HOLDOFF_FRAMES = 8
`endif
) (
  input  logic            clk28,
  input  logic            rst_n,
  input  logic            bus_mreq_rise,
  input  logic            bus_m1,
  input  logic            bus_rd,
  input  logic            bus_ioreq,
  input  logic [15:0]     bus_a,
  input  logic            n_int,
  input  logic            n_int_next,
  input  logic [NREQ-1:0] req,
  input  logic            magic_mode,
  input  logic            magic_map,
  output logic            n_nmi,
  output logic [NREQ-1:0] grant,
  output logic [7:0]      d_out,
  output logic            d_out_active
);

  localparam int IW = $clog2(NREQ);

`ifdef NMI_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE, HOLDOFF} state_t;
  logic [HW-1:0] hold_q, hold_d;
`else
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [NREQ-1:0]        req_q, pend_q, pend_d, clr, win_oh;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d, winner;
  logic [4:0]             cause_q, cause_d;
  logic                   n_nmi_q, n_nmi_d;
  logic [TIMEOUT_W-1:0]   wd_q, wd_d;
  logic                   mm_q, dact_q;
  logic                   frame_edge, ack, mm_fall, cs;

  // First pending index found scanning upward from last+1, wrapping.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] p, input logic [IW-1:0] last);
    logic          found;
    logic [IW-1:0] idx;
    rr_pick = last + IW'(1);
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'(int'(last) + 1 + k);
      if (!found && p[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign frame_edge = n_int & ~n_int_next;
  assign ack        = bus_m1 & bus_mreq_rise & (bus_a == 16'h0066);
  assign mm_fall    = mm_q & ~magic_mode;
  assign cs         = magic_map & bus_ioreq & bus_rd & (bus_a == 16'h12FF);
  assign winner     = rr_pick(pend_q, last_q);

  always_comb begin
    win_oh         = '0;
    win_oh[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cause_d = cause_q;
    n_nmi_d = n_nmi_q;
    wd_d    = wd_q;
    clr     = '0;
`ifdef NMI_HOLDOFF_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_edge && (|pend_q) && !magic_mode) begin
          grant_d = win_oh;
          clr     = win_oh;
          cause_d = {1'b0, win_oh};
          last_d  = winner;
          n_nmi_d = 1'b0;
          wd_d    = '0;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        if (ack) begin
          n_nmi_d = 1'b1;
          state_d = SERVICE;
        end else if (&wd_q) begin
          // CPU never fetched the vector: give up and drop the request.
          n_nmi_d    = 1'b1;
          cause_d[4] = 1'b1;
          grant_d    = '0;
          state_d    = IDLE;
        end
      end
      SERVICE: begin
        if (mm_fall) begin
          grant_d = '0;
`ifdef NMI_HOLDOFF_EN
          hold_d  = '0;
          state_d = HOLDOFF;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef NMI_HOLDOFF_EN
      HOLDOFF: begin
        if (frame_edge) begin
          if (hold_q == HW'(HOLDOFF_FRAMES - 1)) state_d = IDLE;
          else                                   hold_d  = hold_q + HW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // A fresh edge on the granted index re-arms it.
    pend_d = (pend_q & ~clr) | (req & ~req_q);
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cause_q <= '0;
      n_nmi_q <= 1'b1;
      wd_q    <= '0;
      mm_q    <= 1'b0;
      dact_q  <= 1'b0;
`ifdef NMI_HOLDOFF_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cause_q <= cause_d;
      n_nmi_q <= n_nmi_d;
      wd_q    <= wd_d;
      mm_q    <= magic_mode;
      dact_q  <= cs;
`ifdef NMI_HOLDOFF_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign n_nmi        = n_nmi_q;
  assign grant        = grant_q;
  assign d_out        = {3'b000, cause_q};
  assign d_out_active = dact_q;

endmodule

// File: tb/tb_nmi_arbiter.sv
// Scoreboard bench for nmi_arbiter: stimulus queues expected NMI/port events, a monitor checks them.
module tb_nmi_arbiter;

`ifdef NMI_HOLDOFF_EN
  localparam int HOLD_N = 8;
`else
  localparam int HOLD_N = 0;
`endif

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_mreq_rise = 1'b0, bus_m1 = 1'b0, bus_rd = 1'b0, bus_ioreq = 1'b0;
  logic [15:0] bus_a = 16'h0000;
  logic        n_int = 1'b1, n_int_next = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic        magic_mode = 1'b0, magic_map = 1'b0;
  logic        n_nmi;
  logic [3:0]  grant;
  logic [7:0]  d_out;
  logic        d_out_active;

  nmi_arbiter dut (
    .clk28(clk28), .rst_n(rst_n),
    .bus_mreq_rise(bus_mreq_rise), .bus_m1(bus_m1), .bus_rd(bus_rd),
    .bus_ioreq(bus_ioreq), .bus_a(bus_a),
    .n_int(n_int), .n_int_next(n_int_next), .req(req),
    .magic_mode(magic_mode), .magic_map(magic_map),
    .n_nmi(n_nmi), .grant(grant), .d_out(d_out), .d_out_active(d_out_active)
  );

  always #5 clk28 = ~clk28;

  // kind 0: n_nmi fall (grant), 1: d_out_active rise (d_out), 2: n_nmi rise (grant)
  typedef struct { int kind; logic [7:0] val; } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic prev_nmi = 1'b1, prev_dact = 1'b0;

  task automatic push(input int kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic chk_evt(input int kind, input logic [7:0] act, input string nm);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event, actual %h", nm, act);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val !== act) begin
        errors++;
        $display("FAIL %s: actual kind %0d value %h, required kind %0d value %h",
                 nm, kind, act, e.kind, e.val);
      end
    end
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h", nm, act, exp);
    end
  endtask

  always @(negedge clk28) begin
    if (mon_en) begin
      if (prev_nmi && !n_nmi)          chk_evt(0, {4'b0, grant}, "nmi_fall_grant");
      if (!prev_nmi && n_nmi)          chk_evt(2, {4'b0, grant}, "nmi_rise_grant");
      if (!prev_dact && d_out_active)  chk_evt(1, d_out, "port_d_out");
    end
    prev_nmi  <= n_nmi;
    prev_dact <= d_out_active;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  task automatic frame();
    n_int = 1'b1; n_int_next = 1'b0; tick();
    n_int = 1'b0; n_int_next = 1'b1; tick();
    n_int = 1'b1;
  endtask

  task automatic pulse_req(input logic [3:0] m);
    req = m; tick();
    req = 4'b0000; tick();
  endtask

  task automatic fetch66();
    bus_m1 = 1'b1; bus_mreq_rise = 1'b1; bus_a = 16'h0066; tick();
    bus_m1 = 1'b0; bus_mreq_rise = 1'b0; bus_a = 16'h0000;
  endtask

  task automatic port_read();
    magic_map = 1'b1; bus_ioreq = 1'b1; bus_rd = 1'b1; bus_a = 16'h12FF; tick();
    magic_map = 1'b0; bus_ioreq = 1'b0; bus_rd = 1'b0; bus_a = 16'h0000; tick();
    check("port_active_drop", {15'b0, d_out_active}, 16'h0000);
  endtask

  task automatic handler();
    magic_mode = 1'b1; tick(2);
    magic_mode = 1'b0; tick();
    check("grant_clear_after_service", {12'b0, grant}, 16'h0000);
    repeat (HOLD_N) frame();
  endtask

  initial begin
    int cnt;
    tick(3);
    check("reset_n_nmi", {15'b0, n_nmi}, 16'h0001);
    check("reset_grant", {12'b0, grant}, 16'h0000);
    check("reset_d_out", {8'b0, d_out}, 16'h0000);
    check("reset_d_out_active", {15'b0, d_out_active}, 16'h0000);
    rst_n = 1'b1; tick();
    mon_en = 1'b1;

    // Single magic request, full service and cause read
    pulse_req(4'b0001);
    push(0, 8'h01); frame();
    push(2, 8'h01); fetch66();
    check("n_nmi_released_on_ack", {15'b0, n_nmi}, 16'h0001);
    push(1, 8'h01); port_read();
    handler();

    // Simultaneous pause and external, last=0 -> pause first, then external
    pulse_req(4'b1010);
    push(0, 8'h02); frame();
    push(2, 8'h02); fetch66();
    handler();
    push(0, 8'h08); frame();
    push(2, 8'h08); fetch66();
    push(1, 8'h08); port_read();
    handler();

    // Requests held off while magic_mode is high
    magic_mode = 1'b1; tick();
    pulse_req(4'b0100);
    for (int f = 0; f < 3; f++) begin
      frame();
      check("n_nmi_blocked_magic_mode", {15'b0, n_nmi}, 16'h0001);
    end
    magic_mode = 1'b0; tick();
    push(0, 8'h04); frame();
    push(2, 8'h04); fetch66();
    handler();

    // Request pending at magic_mode fall waits out the holdoff
    pulse_req(4'b1000);
    push(0, 8'h08); frame();
    push(2, 8'h08); fetch66();
    magic_mode = 1'b1; tick();
    pulse_req(4'b0001);
    magic_mode = 1'b0; tick();
    for (int f = 0; f < HOLD_N; f++) begin
      frame();
      check("holdoff_no_grant", {15'b0, n_nmi}, 16'h0001);
    end
    push(0, 8'h01); frame();

    // No vector fetch: watchdog releases n_nmi and flags timeout
    push(2, 8'h00);
    cnt = 0;
    while (n_nmi == 1'b0 && cnt < 70000) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt + 1 < 65535 || cnt + 1 > 65536) begin
      errors++;
      $display("FAIL watchdog_duration: actual %0d cycles low, required 65535..65536", cnt + 1);
    end
    check("timeout_grant", {12'b0, grant}, 16'h0000);
    push(1, 8'h11); port_read();
    frame();
    check("timeout_not_repended", {15'b0, n_nmi}, 16'h0001);

    // Asynchronous reset in the middle of ASSERT
    pulse_req(4'b0010);
    push(0, 8'h02); frame();
    check("assert_before_reset", {15'b0, n_nmi}, 16'h0000);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_n_nmi", {15'b0, n_nmi}, 16'h0001);
    check("async_reset_grant", {12'b0, grant}, 16'h0000);
    tick(2);
    rst_n = 1'b1; tick(2);
    mon_en = 1'b1;
    frame();
    check("reset_cleared_pend", {15'b0, n_nmi}, 16'h0001);
    pulse_req(4'b1001);
    push(0, 8'h01); frame();
    push(2, 8'h01); fetch66();
    handler();

    tick(4);
    check("scoreboard_drained", q.size(), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
